exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage: consumes the ID→EX pipeline register outputs, computes Val2, runs the ALU and owns the architectural NZCV status register.
- Resolves branch target/flush and registers results into the EX→MEM pipeline register.
- Sits between the ID/EX register and the memory stage; forwarding selects come from the hazard/forwarding unit.

Parameters:
- WIDTH, 32, datapath width.
- REG_W, 4, register-index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- freeze  in  1  hold EX/MEM register and status register (memory stall)
- MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, Imm_in, B_in, S_in  in  1 each  control from ID/EX
- EX_CMD_in  in  4  ALU command
- status_in  in  4  {N,Z,C,V} snapshot carried from ID
- Dest_in  in  REG_W  destination register
- shifter_operand_in  in  12  operand2 field
- signed_immediate_in  in  24  branch offset
- PC_in, Val_Rn_in, Val_Rm_in  in  WIDTH each
- sel_src1, sel_src2  in  2 each  forward select: 0=reg, 1=MEM ALU result, 2=WB value, 3=reg
- MEM_ALU_Res, WB_Value  in  WIDTH each  forwarding sources
- Branch_Taken  out  1  combinational; equals B_in; used as ID/IF flush
- Branch_Address  out  WIDTH  combinational target
- status_reg  out  4  registered NZCV to ID condition check
- WB_EN_out, MEM_R_EN_out, MEM_W_EN_out  out  1 each  registered
- ALU_Res_out, Val_Rm_out  out  WIDTH each  registered
- Dest_out  out  REG_W  registered

Behaviour:
- Reset: every registered output and status_reg = 0 immediately on rst. Reset takes priority over freeze.
- Latency: 1 cycle from ID/EX outputs to EX/MEM outputs. Status updates on the same edge.
- Operand A = forward mux(sel_src1) of Val_Rn_in. Store data = forward mux(sel_src2) of Val_Rm_in; it drives both shifter input and Val_Rm_out.
- Val2:
  - Imm_in=1: zero-extended imm8 = shifter[7:0], rotated right by 2*shifter[11:8].
  - Else if MEM_R_EN_in|MEM_W_EN_in: zero-extend shifter[11:0].
  - Else: Rm shifted by shifter[11:7], type shifter[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. Shift amount 0 = pass-through.
- ALU (EX_CMD): 0001 MOV B; 1001 MVN ~B; 0010 ADD; 0011 ADC A+B+C; 0100 SUB A-B; 0101 SBC A-B-~C; 0110 AND; 0111 ORR; 1000 EOR. Others: result 0, flags unchanged.
- Flags:
  - N = res[31]; Z = (res == 0).
  - C: carry-out for add forms; NOT borrow for subtract forms; logic/move keeps status_in C.
  - V: signed overflow for arithmetic; logic keeps status_in V.
  - Carry-in for ADC/SBC comes from status_in[1].
- Status register loads {N,Z,C,V} when S_in=1 and freeze=0; otherwise holds.
- Branch_Address = PC_in + (sign_extend(signed_immediate_in) << 2), 32-bit wrap.
- EX/MEM register:
  - freeze=0: capture WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, ALU result, store data, Dest_in.
  - freeze=1: hold all values.
- Bubbles from an ID/EX flush arrive as all-zero controls and pass through as no-ops. S=0, so status is untouched.
- Reset asserted mid-stall: clears everything. Registers resume capture on the first edge with rst=0 and freeze=0.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined: sel_src1/sel_src2 muxes active as above.
- Undefined: muxes removed, A = Val_Rn_in, store data = Val_Rm_in. sel_*, MEM_ALU_Res and WB_Value are ignored (ports retained).

Decomposition:
- Shared package: EX_CMD encodings, shift-type codes, forward-select codes, NZCV bit indices.
- Natural sub-module: val2_generator (combinational shifter/rotator).
- ALU, status register and EX/MEM register stay in exe_stage.

Test Plan:
- ADD with S=1: Rn=0x7FFFFFFF, Imm=1, shifter=0x001 → ALU_Res=0x80000000 next edge; status_reg=1001 (N,V).
- SUB with S=1: Rn=5, Rm=5, shift 0 → ALU_Res=0, status_reg=0110 (Z,C).
- Immediate rotate: shifter=0x4FF → Val2=0xFF000000; MOV → ALU_Res=0xFF000000.
- Branch: B_in=1, PC=0x100, imm24=0xFFFFFE → Branch_Taken=1, Branch_Address=0xF8 same cycle.
- Freeze: freeze=1 for 3 cycles with changing inputs and S=1 → EX/MEM outputs and status_reg constant; rst pulse during freeze → all outputs 0.
- FORWARDING_EN: sel_src1=1, MEM_ALU_Res=10, Val_Rn=3, ADD imm 1 → ALU_Res=11. Without the macro → ALU_Res=4.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// Shared encodings for the execute stage: ALU commands, shift types,
// forward selects and NZCV bit positions.
package exe_stage_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

endpackage

// File: rtl/exe_stage_val2_generator.sv
// Operand-2 generator: rotated imm8, zero-extended memory offset,
// or register shifted by an immediate amount.
module val2_generator
    import exe_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             imm,
    input  logic             mem_en,
    input  logic [11:0]      shifter_operand,
    input  logic [WIDTH-1:0] val_rm,
    output logic [WIDTH-1:0] val2
);

    function automatic logic [WIDTH-1:0] rotr(
        input logic [WIDTH-1:0] x,
        input logic [4:0]       r
    );
        return (x >> r) | (x << (WIDTH - int'(r)));
    endfunction

    logic [4:0]       rot;
    logic [4:0]       amt;
    logic [WIDTH-1:0] imm_ext;

    assign rot     = {shifter_operand[11:8], 1'b0};
    assign amt     = shifter_operand[11:7];
    assign imm_ext = WIDTH'(shifter_operand[7:0]);

    always_comb begin
        val2 = val_rm;
        if (imm) begin
            val2 = rotr(imm_ext, rot);
        end else if (mem_en) begin
            val2 = WIDTH'(shifter_operand);
        end else begin
            unique case (shift_t'(shifter_operand[6:5]))
                SH_LSL: val2 = val_rm << amt;
                SH_LSR: val2 = val_rm >> amt;
                SH_ASR: val2 = $signed(val_rm) >>> amt;
                SH_ROR: val2 = rotr(val_rm, amt);
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, Val2, ALU, NZCV status and EX/MEM register.
// Define FORWARDING_EN to enable the sel_src1/sel_src2 forwarding muxes.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int REG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             MEM_R_EN_in,
    input  logic             MEM_W_EN_in,
    input  logic             WB_EN_in,
    input  logic             Imm_in,
    input  logic             B_in,
    input  logic             S_in,
    input  logic [3:0]       EX_CMD_in,
    input  logic [3:0]       status_in,
    input  logic [REG_W-1:0] Dest_in,
    input  logic [11:0]      shifter_operand_in,
    input  logic [23:0]      signed_immediate_in,
    input  logic [WIDTH-1:0] PC_in,
    input  logic [WIDTH-1:0] Val_Rn_in,
    input  logic [WIDTH-1:0] Val_Rm_in,
    input  logic [1:0]       sel_src1,
    input  logic [1:0]       sel_src2,
    input  logic [WIDTH-1:0] MEM_ALU_Res,
    input  logic [WIDTH-1:0] WB_Value,
    output logic             Branch_Taken,
    output logic [WIDTH-1:0] Branch_Address,
    output logic [3:0]       status_reg,
    output logic             WB_EN_out,
    output logic             MEM_R_EN_out,
    output logic             MEM_W_EN_out,
    output logic [WIDTH-1:0] ALU_Res_out,
    output logic [WIDTH-1:0] Val_Rm_out,
    output logic [REG_W-1:0] Dest_out
);

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] st_data;
    logic [WIDTH-1:0] val2;
    logic             unused_ok;

`ifdef FORWARDING_EN
    always_comb begin
        unique case (sel_src1)
            FWD_MEM: op_a = MEM_ALU_Res;
            FWD_WB:  op_a = WB_Value;
            default: op_a = Val_Rn_in;
        endcase
        unique case (sel_src2)
            FWD_MEM: st_data = MEM_ALU_Res;
            FWD_WB:  st_data = WB_Value;
            default: st_data = Val_Rm_in;
        endcase
    end
    assign unused_ok = ^{status_in[N_BIT], status_in[Z_BIT]};
`else
    assign op_a      = Val_Rn_in;
    assign st_data   = Val_Rm_in;
    assign unused_ok = ^{status_in[N_BIT], status_in[Z_BIT], sel_src1,
                         sel_src2, MEM_ALU_Res, WB_Value};
`endif

    val2_generator #(.WIDTH(WIDTH)) u_val2 (
        .imm             (Imm_in),
        .mem_en          (MEM_R_EN_in | MEM_W_EN_in),
        .shifter_operand (shifter_operand_in),
        .val_rm          (st_data),
        .val2            (val2)
    );

    assign Branch_Taken   = B_in;
    assign Branch_Address = PC_in +
        {{(WIDTH-26){signed_immediate_in[23]}}, signed_immediate_in, 2'b00};

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             arith, sub, cin_eff, cmd_ok;
    logic             flag_c, flag_v;

    always_comb begin
        arith   = 1'b0;
        sub     = 1'b0;
        cin_eff = 1'b0;
        cmd_ok  = 1'b1;
        res     = '0;
        unique case (EX_CMD_in)
            CMD_MOV: res = val2;
            CMD_MVN: res = ~val2;
            CMD_AND: res = op_a & val2;
            CMD_ORR: res = op_a | val2;
            CMD_EOR: res = op_a ^ val2;
            CMD_ADD: arith = 1'b1;
            CMD_ADC: begin
                arith   = 1'b1;
                cin_eff = status_in[C_BIT];
            end
            CMD_SUB: begin
                arith   = 1'b1;
                sub     = 1'b1;
                cin_eff = 1'b1;
            end
            CMD_SBC: begin
                arith   = 1'b1;
                sub     = 1'b1;
                cin_eff = status_in[C_BIT];
            end
            default: cmd_ok = 1'b0;
        endcase
        // Subtraction as A + ~B + cin, so carry-out is NOT borrow
        opb    = sub ? ~val2 : val2;
        sum    = {1'b0, op_a} + {1'b0, opb} + {{WIDTH{1'b0}}, cin_eff};
        flag_c = status_in[C_BIT];
        flag_v = status_in[V_BIT];
        if (arith) begin
            res    = sum[WIDTH-1:0];
            flag_c = sum[WIDTH];
            flag_v = (op_a[WIDTH-1] == opb[WIDTH-1]) &&
                     (res[WIDTH-1] != op_a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_reg <= '0;
        end else if (!freeze && S_in && cmd_ok) begin
            status_reg <= {res[WIDTH-1], (res == '0), flag_c, flag_v};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_EN_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
            MEM_W_EN_out <= 1'b0;
            ALU_Res_out  <= '0;
            Val_Rm_out   <= '0;
            Dest_out     <= '0;
        end else if (!freeze) begin
            WB_EN_out    <= WB_EN_in;
            MEM_R_EN_out <= MEM_R_EN_in;
            MEM_W_EN_out <= MEM_W_EN_in;
            ALU_Res_out  <= res;
            Val_Rm_out   <= st_data;
            Dest_out     <= Dest_in;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed + random bench for exe_stage against an arithmetic reference model.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in;
    logic        Imm_in, B_in, S_in;
    logic [3:0]  EX_CMD_in, status_in, Dest_in;
    logic [11:0] shifter_operand_in;
    logic [23:0] signed_immediate_in;
    logic [31:0] PC_in, Val_Rn_in, Val_Rm_in, MEM_ALU_Res, WB_Value;
    logic [1:0]  sel_src1, sel_src2;
    logic        Branch_Taken;
    logic [31:0] Branch_Address;
    logic [3:0]  status_reg;
    logic        WB_EN_out, MEM_R_EN_out, MEM_W_EN_out;
    logic [31:0] ALU_Res_out, Val_Rm_out;
    logic [3:0]  Dest_out;

    exe_stage #(.WIDTH(32), .REG_W(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
        .WB_EN_in(WB_EN_in), .Imm_in(Imm_in), .B_in(B_in), .S_in(S_in),
        .EX_CMD_in(EX_CMD_in), .status_in(status_in), .Dest_in(Dest_in),
        .shifter_operand_in(shifter_operand_in),
        .signed_immediate_in(signed_immediate_in),
        .PC_in(PC_in), .Val_Rn_in(Val_Rn_in), .Val_Rm_in(Val_Rm_in),
        .sel_src1(sel_src1), .sel_src2(sel_src2),
        .MEM_ALU_Res(MEM_ALU_Res), .WB_Value(WB_Value),
        .Branch_Taken(Branch_Taken), .Branch_Address(Branch_Address),
        .status_reg(status_reg), .WB_EN_out(WB_EN_out),
        .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out),
        .ALU_Res_out(ALU_Res_out), .Val_Rm_out(Val_Rm_out),
        .Dest_out(Dest_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic        exp_wb, exp_mr, exp_mw;
    logic [31:0] exp_res, exp_rm;
    logic [3:0]  exp_dest, exp_status;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_regs();
        chk("wb_en",    WB_EN_out,    exp_wb);
        chk("mem_r_en", MEM_R_EN_out, exp_mr);
        chk("mem_w_en", MEM_W_EN_out, exp_mw);
        chk("alu_res",  ALU_Res_out,  exp_res);
        chk("val_rm",   Val_Rm_out,   exp_rm);
        chk("dest",     Dest_out,     exp_dest);
        chk("status",   status_reg,   exp_status);
    endtask

    task automatic clear_exp();
        exp_wb = 0; exp_mr = 0; exp_mw = 0;
        exp_res = 0; exp_rm = 0; exp_dest = 0; exp_status = 0;
    endtask

    task automatic zero_inputs();
        freeze = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 0; WB_EN_in = 0;
        Imm_in = 0; B_in = 0; S_in = 0; EX_CMD_in = 0; status_in = 0;
        Dest_in = 0; shifter_operand_in = 0; signed_immediate_in = 0;
        PC_in = 0; Val_Rn_in = 0; Val_Rm_in = 0;
        MEM_ALU_Res = 0; WB_Value = 0; sel_src1 = 0; sel_src2 = 0;
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] sel,
                                        input logic [31:0] v);
`ifdef FORWARDING_EN
        if (sel == 2'd1) return MEM_ALU_Res;
        if (sel == 2'd2) return WB_Value;
`endif
        return v;
    endfunction

    function automatic logic [31:0] rot_right(input logic [31:0] x, input int r);
        logic [63:0] d;
        d = {x, x} >> r;
        return d[31:0];
    endfunction

    // Reference: operand2 and ALU computed with wide integer arithmetic
    function automatic void ref_exec(output logic [31:0] res,
                                     output logic [3:0] nzcv,
                                     output bit valid);
        logic [31:0] a, rm, b;
        longint unsigned u;
        longint s;
        int amt, carry_in, bor;
        logic c, v;
        a  = fwd(sel_src1, Val_Rn_in);
        rm = fwd(sel_src2, Val_Rm_in);
        amt = int'(shifter_operand_in[11:7]);
        if (Imm_in)
            b = rot_right(32'(shifter_operand_in[7:0]),
                          2 * int'(shifter_operand_in[11:8]));
        else if (MEM_R_EN_in || MEM_W_EN_in)
            b = 32'(shifter_operand_in);
        else case (shifter_operand_in[6:5])
            2'd0: b = rm << amt;
            2'd1: b = rm >> amt;
            2'd2: b = 32'($signed(rm) >>> amt);
            default: b = rot_right(rm, amt);
        endcase
        c = status_in[1];
        v = status_in[0];
        valid = 1;
        carry_in = int'(status_in[1]);
        case (EX_CMD_in)
            4'd1: res = b;
            4'd9: res = ~b;
            4'd6: res = a & b;
            4'd7: res = a | b;
            4'd8: res = a ^ b;
            4'd2, 4'd3: begin
                if (EX_CMD_in == 4'd2) carry_in = 0;
                u = longint'(a) + longint'(b) + longint'(carry_in);
                s = longint'($signed(a)) + longint'($signed(b)) + carry_in;
                res = u[31:0];
                c = u[32];
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4, 4'd5: begin
                bor = (EX_CMD_in == 4'd5) ? 1 - carry_in : 0;
                s = longint'($signed(a)) - longint'($signed(b)) - bor;
                res = a - b - 32'(bor);
                c = (longint'(a) >= longint'(b) + longint'(bor));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            default: begin
                res = 0;
                valid = 0;
            end
        endcase
        nzcv = {res[31], res == 32'd0, c, v};
    endfunction

    // Entered and left at posedge+1 with inputs already driven
    task automatic run_cycle();
        logic [31:0] r;
        logic [3:0] f;
        bit ok;
        int off;
        #1;
        off = int'($signed(signed_immediate_in)) * 4;
        chk("br_taken", Branch_Taken, B_in);
        chk("br_addr", Branch_Address, PC_in + 32'(off));
        ref_exec(r, f, ok);
        if (!freeze) begin
            exp_wb = WB_EN_in; exp_mr = MEM_R_EN_in; exp_mw = MEM_W_EN_in;
            exp_res = r; exp_rm = fwd(sel_src2, Val_Rm_in); exp_dest = Dest_in;
            if (S_in && ok) exp_status = f;
        end
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic randomize_inputs();
        MEM_R_EN_in = ($urandom_range(0, 3) == 0);
        MEM_W_EN_in = ($urandom_range(0, 3) == 0);
        WB_EN_in = 1'($urandom);
        Imm_in = ($urandom_range(0, 2) == 0);
        B_in = 1'($urandom);
        S_in = 1'($urandom);
        EX_CMD_in = 4'($urandom_range(0, 15));
        status_in = 4'($urandom);
        Dest_in = 4'($urandom);
        shifter_operand_in = 12'($urandom);
        signed_immediate_in = 24'($urandom);
        PC_in = $urandom; Val_Rn_in = $urandom; Val_Rm_in = $urandom;
        MEM_ALU_Res = $urandom; WB_Value = $urandom;
        sel_src1 = 2'($urandom); sel_src2 = 2'($urandom);
    endtask

    initial begin
        zero_inputs();
        clear_exp();
        #2 rst = 1;
        #2 check_regs();
        @(posedge clk);
        #1 rst = 0;

        EX_CMD_in = 4'b0010; S_in = 1; Imm_in = 1;
        Val_Rn_in = 32'h7FFF_FFFF; shifter_operand_in = 12'h001;
        run_cycle();
        chk("tp_add_res", ALU_Res_out, 32'h8000_0000);
        chk("tp_add_nzcv", status_reg, 4'b1001);

        zero_inputs();
        EX_CMD_in = 4'b0100; S_in = 1; Val_Rn_in = 5; Val_Rm_in = 5;
        run_cycle();
        chk("tp_sub_res", ALU_Res_out, 32'd0);
        chk("tp_sub_nzcv", status_reg, 4'b0110);

        zero_inputs();
        EX_CMD_in = 4'b0001; Imm_in = 1; shifter_operand_in = 12'h4FF;
        run_cycle();
        chk("tp_mov_rot", ALU_Res_out, 32'hFF00_0000);
        chk("tp_mov_nzcv", status_reg, 4'b0110);

        zero_inputs();
        B_in = 1; PC_in = 32'h100; signed_immediate_in = 24'hFFFFFE;
        run_cycle();
        chk("tp_br_taken", Branch_Taken, 1);
        chk("tp_br_addr", Branch_Address, 32'hF8);

        zero_inputs();
        EX_CMD_in = 4'b0010; Imm_in = 1; shifter_operand_in = 12'h001;
        sel_src1 = 2'd1; MEM_ALU_Res = 10; Val_Rn_in = 3;
        run_cycle();
`ifdef FORWARDING_EN
        chk("tp_fwd", ALU_Res_out, 32'd11);
`else
        chk("tp_fwd", ALU_Res_out, 32'd4);
`endif

        zero_inputs();
        EX_CMD_in = 4'b0111; S_in = 1; WB_EN_in = 1; Dest_in = 4'hA;
        Val_Rn_in = 32'h8000_0000; Val_Rm_in = 32'h1234;
        run_cycle();
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            freeze = 1; S_in = 1;
            run_cycle();
        end
        chk("tp_frz_res", ALU_Res_out, 32'h8000_1234);
        chk("tp_frz_nzcv", status_reg, 4'b1000);

        rst = 1;
        #1;
        clear_exp();
        check_regs();
        @(posedge clk);
        #1 rst = 0;
        randomize_inputs();
        freeze = 1; S_in = 1; EX_CMD_in = 4'b0010;
        run_cycle();
        freeze = 0;
        run_cycle();

        zero_inputs();
        run_cycle();

        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            freeze = ($urandom_range(0, 7) == 0);
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
